// File: rtl/shr_unit.sv
// shr_unit: sequential right-shift register with start/busy/done handshake.
// Loads a word and a carry-in, then shifts right one bit per clock, amt times.
// Build option: define SHR_ROTATE_EN for rotate mode (fill = f[0], cin ignored);
// without it the register shifts logically (cin first, zeros afterwards).
module shr_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_fill;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

`ifdef SHR_ROTATE_EN
  // Rotate mode: the bit leaving the LSB re-enters at the MSB on every shift
  always_comb begin
    w_fill = r_f[0];
  end
`else
  logic r_first;
  logic r_cin;

  // Logical mode: the latched carry-in enters on the first shift, zeros after
  always_comb begin
    w_fill = 1'b0;
    if (r_first) begin
      w_fill = r_cin;
    end
  end

  // Latch cin at accept and track whether the next shift is the first one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b0;
      r_cin   <= 1'b0;
    end else if (w_accept) begin
      r_first <= 1'b1;
      r_cin   <= cin;
    end else if (r_state == SHIFT) begin
      r_first <= 1'b0;
    end
  end
`endif

  // Next-state decode; start is only honoured in IDLE or DONE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept = 1'b1;
          if (amt != '0) begin
            w_next = SHIFT;
          end else begin
            w_next = DONE;
          end
        end else if (r_state == DONE) begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_count == CNT_W'(1)) begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register plus the registered done pulse (high exactly while in DONE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE);
    end
  end

  // Datapath: load on accept, shift right through cout while in SHIFT, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_f     <= d;
      r_cout  <= 1'b0;
      r_count <= amt;
    end else if (r_state == SHIFT) begin
      r_f     <= {w_fill, r_f[WIDTH-1:1]};
      r_cout  <= r_f[0];
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign f    = r_f;
  assign cout = r_cout;
  assign busy = (r_state == SHIFT);
  assign done = r_done;

endmodule
